// File: rtl/fifo_ctrl_sync_pkg.sv
// Shared helpers for the synchronous FIFO controller and its storage array.
package fifo_ctrl_sync_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ctrl_sync_array.sv
// Behavioural storage array: synchronous write, registered read, no reset.
module array_behavioral_simple
  import fifo_ctrl_sync_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDR  = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             write_en,
  input  logic [ADDR-1:0]  write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [ADDR-1:0]  read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/fifo_ctrl_sync.sv
// Synchronous FIFO controller: circular pointers, occupancy count and
// valid/ready handshakes around a registered-read storage array.
module fifo_ctrl_sync
  import fifo_ctrl_sync_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDR  = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned   CW       = ADDR + 1;
  localparam logic [ADDR:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [ADDR-1:0]  rd_ptr_next;
  logic [WIDTH-1:0] read_data;
  logic [ADDR:0]    remain;
  logic             push;
  logic             pop;
  logic             write_en;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign write_en = push & !flush;

  // Reading at the post-pop pointer lets the array register the next head
  // on the same edge as the pop, sustaining one pop per cycle.
  always_comb begin
    rd_ptr_next = rd_ptr;
    if (pop) begin
      rd_ptr_next = rd_ptr + ADDR'(1);
    end
  end

  assign remain   = count - CW'(pop);
  assign out_data = out_valid ? read_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR'(1);
      end
      rd_ptr <= rd_ptr_next;
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // Pre-edge count excludes a same-cycle push, giving the one-cycle
      // write-to-read latency the registered array needs.
      out_valid <= (remain != '0);
    end
  end

  array_behavioral_simple #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_array (
    .clk        (clk),
    .write_en   (write_en),
    .write_addr (wr_ptr),
    .write_data (in_data),
    .read_addr  (rd_ptr_next),
    .read_data  (read_data)
  );

endmodule
